// File: rtl/drive_sequencer.sv
// Command sequencer for the motor control block: brake dead-time on direction
// changes, gradual speed ramp, stall-fault latch. All outputs registered.
module drive_sequencer #(
    parameter int BRAKE_CYC  = 50000,
    parameter int RAMP_DIV   = 100000,
    parameter int RAMP_START = 8,
    parameter int STALL_CYC  = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] dir_req,
    input  logic [5:0] speed_req,
    input  logic       go,
    input  logic       brake_req,
    input  logic       st_in,
    input  logic       fault_clr,
    output logic [2:0] Direction,
    output logic       brake,
    output logic       coast,
    output logic [5:0] sw,
    output logic       busy,
    output logic       fault
);

    localparam int RW  = ($clog2(RAMP_DIV) > 17) ? $clog2(RAMP_DIV) : 17;
    localparam int BW  = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
    localparam int SCW = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;

    localparam logic [RW-1:0]  RAMP_LAST  = RW'(RAMP_DIV - 1);
    localparam logic [BW-1:0]  BRK_LAST   = BW'(BRAKE_CYC - 1);
    localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_CYC - 1);
    localparam logic [5:0]     START_SW   = (RAMP_START > 63) ? 6'd63 : 6'(RAMP_START);

    typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} state_t;

    state_t         state;
    logic [RW-1:0]  ramp_cnt;
    logic [BW-1:0]  brake_cnt;
    logic [SCW-1:0] stall_cnt;
    logic [5:0]     start_sw;

    assign start_sw = (speed_req < START_SW) ? speed_req : START_SW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            Direction <= 3'd0;
            brake     <= 1'b0;
            coast     <= 1'b1;
            sw        <= 6'd0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            ramp_cnt  <= '0;
            brake_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (go && !brake_req) begin
                        state     <= RUN;
                        Direction <= dir_req;
                        sw        <= start_sw;
                        coast     <= 1'b0;
                        ramp_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (st_in && stall_cnt == STALL_LAST) begin
                        state     <= FAULT;
                        brake     <= 1'b1;
                        sw        <= 6'd0;
                        fault     <= 1'b1;
                        stall_cnt <= '0;
                    end else if (brake_req || (go && dir_req != Direction)) begin
                        // Old Direction is kept until the dead-time expires
                        state     <= BRAKE;
                        brake     <= 1'b1;
                        sw        <= 6'd0;
                        busy      <= 1'b1;
                        brake_cnt <= '0;
                        stall_cnt <= '0;
                    end else if (!go) begin
                        state     <= IDLE;
                        coast     <= 1'b1;
                        sw        <= 6'd0;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= st_in ? stall_cnt + SCW'(1) : '0;
                        if (ramp_cnt == RAMP_LAST) begin
                            ramp_cnt <= '0;
                            if (sw < speed_req)
                                sw <= sw + 6'd1;
                        end else begin
                            ramp_cnt <= ramp_cnt + RW'(1);
                        end
                        // Decreases win over the ramp and take effect at once
                        if (speed_req < sw)
                            sw <= speed_req;
                    end
                end
                BRAKE: begin
                    if (brake_cnt != BRK_LAST) begin
                        brake_cnt <= brake_cnt + BW'(1);
                    end else if (!brake_req) begin
                        brake <= 1'b0;
                        busy  <= 1'b0;
                        if (go) begin
                            state     <= RUN;
                            Direction <= dir_req;
                            sw        <= start_sw;
                            ramp_cnt  <= '0;
                        end else begin
                            state <= IDLE;
                            coast <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    if (fault_clr && !go) begin
                        state <= IDLE;
                        brake <= 1'b0;
                        coast <= 1'b1;
                        fault <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed vector bench for drive_sequencer: one table row per clock, plus an
// asynchronous mid-BRAKE reset sequence.
module tb_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dir_req;
    logic [5:0] speed_req;
    logic       go, brake_req, st_in, fault_clr;
    logic [2:0] Direction;
    logic       brake, coast, busy, fault;
    logic [5:0] sw;

    int total = 0;
    int bad   = 0;

    drive_sequencer #(
        .BRAKE_CYC(4), .RAMP_DIV(3), .RAMP_START(8), .STALL_CYC(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir_req(dir_req), .speed_req(speed_req),
        .go(go), .brake_req(brake_req), .st_in(st_in), .fault_clr(fault_clr),
        .Direction(Direction), .brake(brake), .coast(coast), .sw(sw),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       go, brq, st, fclr;
        logic [2:0] dir;
        logic [5:0] spd;
        logic [2:0] edir;
        logic       ebrk, ecoast;
        logic [5:0] esw;
        logic       ebusy, efault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input int g, input int brq, input int st,
                       input int fclr, input int dir, input int spd, input int edir,
                       input int ebrk, input int ecoast, input int esw,
                       input int ebusy, input int efault);
        vec_t v;
        v.name = name; v.go = 1'(g); v.brq = 1'(brq); v.st = 1'(st); v.fclr = 1'(fclr);
        v.dir = 3'(dir); v.spd = 6'(spd); v.edir = 3'(edir); v.ebrk = 1'(ebrk);
        v.ecoast = 1'(ecoast); v.esw = 6'(esw); v.ebusy = 1'(ebusy); v.efault = 1'(efault);
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name, input logic [2:0] edir, input logic ebrk,
                             input logic ecoast, input logic [5:0] esw,
                             input logic ebusy, input logic efault);
        total++;
        if ({Direction, brake, coast, sw, busy, fault} !== {edir, ebrk, ecoast, esw, ebusy, efault}) begin
            bad++;
            $display("FAIL %s: got dir=%0d brake=%0b coast=%0b sw=%0d busy=%0b fault=%0b, want dir=%0d brake=%0b coast=%0b sw=%0d busy=%0b fault=%0b",
                     name, Direction, brake, coast, sw, busy, fault,
                     edir, ebrk, ecoast, esw, ebusy, efault);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        total++;
        if (brake && coast) begin
            bad++;
            $display("FAIL brake_coast_excl: got brake=1 coast=1, want not both");
        end
    endtask

    initial begin
        // Ramp from RAMP_START toward speed_req, one step per 3 cycles
        for (int i = 0; i < 10; i++)
            add("ramp", 1,0,0,0, 1,10, 1,0,0, (i < 3) ? 8 : (i < 6) ? 9 : 10, 0,0);
        for (int i = 0; i < 4; i++)
            add("dirchg_brk", 1,0,0,0, 2,10, 1,1,0,0,1,0);
        add("dirchg_run",   1,0,0,0, 2,10, 2,0,0,8,0,0);
        add("run",          1,0,0,0, 2,10, 2,0,0,8,0,0);
        for (int i = 0; i < 10; i++)
            add("brkreq_hold", 1,1,0,0, 2,10, 2,1,0,0,1,0);
        add("brkreq_rel",   1,0,0,0, 2,10, 2,0,0,8,0,0);
        for (int i = 0; i < 4; i++)
            add("stall_a",  1,0,1,0, 2,8, 2,0,0,8,0,0);
        add("stall_gap",    1,0,0,0, 2,8, 2,0,0,8,0,0);
        for (int i = 0; i < 4; i++)
            add("stall_b",  1,0,1,0, 2,8, 2,0,0,8,0,0);
        add("stall_trip",   1,0,1,0, 2,8, 2,1,0,0,0,1);
        add("fclr_go_ign",  1,0,0,1, 2,8, 2,1,0,0,0,1);
        add("fault_hold",   0,0,0,0, 2,8, 2,1,0,0,0,1);
        add("fclr",         0,0,0,1, 2,8, 2,0,1,0,0,0);
        add("idle",         0,0,0,0, 2,8, 2,0,1,0,0,0);
        add("idle_brq",     1,1,0,0, 3,5, 2,0,1,0,0,0);
        add("run_clip",     1,0,0,0, 3,5, 3,0,0,5,0,0);
        add("sw_dec",       1,0,0,0, 3,2, 3,0,0,2,0,0);
        add("go_off",       0,0,0,0, 3,2, 3,0,1,0,0,0);
        add("run2",         1,0,0,0, 3,2, 3,0,0,2,0,0);
        add("dir_brk",      1,0,0,0, 4,2, 3,1,0,0,1,0);
        for (int i = 0; i < 3; i++)
            add("brk_go0",  0,0,0,0, 4,2, 3,1,0,0,1,0);
        add("brk_idle",     0,0,0,0, 4,2, 3,0,1,0,0,0);
        add("run3",         1,0,1,0, 4,2, 4,0,0,2,0,0);
        for (int i = 0; i < 4; i++)
            add("stall_c",  1,0,1,0, 4,2, 4,0,0,2,0,0);
        add("stall_over_brq", 1,1,1,0, 5,2, 4,1,0,0,0,1);
        add("fclr2",        0,0,0,1, 5,2, 4,0,1,0,0,0);

        rst_n = 1'b0; go = 1'b0; brake_req = 1'b0; st_in = 1'b0; fault_clr = 1'b0;
        dir_req = 3'd0; speed_req = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 3'd0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            go = vecs[i].go; brake_req = vecs[i].brq; st_in = vecs[i].st;
            fault_clr = vecs[i].fclr; dir_req = vecs[i].dir; speed_req = vecs[i].spd;
            step();
            check_out($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].edir, vecs[i].ebrk,
                      vecs[i].ecoast, vecs[i].esw, vecs[i].ebusy, vecs[i].efault);
        end

        // Asynchronous reset in the middle of a brake window
        go = 1'b1; brake_req = 1'b0; st_in = 1'b0; fault_clr = 1'b0;
        dir_req = 3'd6; speed_req = 6'd10;
        step();
        check_out("pre_rst_run", 3'd6, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
        dir_req = 3'd7;
        step();
        step();
        check_out("pre_rst_brk", 3'd6, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 3'd0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
        go = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check_out("post_rst_idle", 3'd0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Upstream command stage for the motor control block. Converts raw drive requests (direction code, speed, go/brake levels) into the registered `Direction`, `brake`, `coast` and `sw` signals that the motor control block consumes. Enforces a timed brake dead-time on every direction change, ramps speed up gradually, and latches a fault when the stall indication persists.

## Interface
- `BRAKE_CYC`, default 50000: cycles `brake` is held on a direction change, minimum.
- `RAMP_DIV`, default 100000: cycles between successive +1 speed steps.
- `RAMP_START`, default 8: initial `sw` on entry to RUN, clipped to `speed_req`.
- `STALL_CYC`, default 1000000: consecutive `st_in`-high cycles in RUN that trigger a fault.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dir_req`  in  3  requested direction code. Opaque: only equality is compared.
- `speed_req`  in  6  requested speed.
- `go`  in  1  level; 1 = drive, 0 = release to coast.
- `brake_req`  in  1  level; forces braking while high.
- `st_in`  in  1  stall indication from the stall detector.
- `fault_clr`  in  1  pulse; clears a latched fault.
- `Direction`  out  3  direction code to motor control.
- `brake`  out  1  brake command.
- `coast`  out  1  coast command.
- `sw`  out  6  speed to motor control.
- `busy`  out  1  high while in BRAKE.
- `fault`  out  1  latched stall fault.

## Operation
- All outputs are registered. Reset values: `Direction`=000, `brake`=0, `coast`=1, `sw`=0, `busy`=0, `fault`=0, state IDLE. All counters are cleared on reset.
- The FSM evaluates conditions in this priority order: stall fault > `brake_req` > `go`=0 > direction change > ramp step.
- **IDLE**
  - Outputs: `coast`=1, `brake`=0, `sw`=0.
  - Exits to RUN when `go`=1 and `brake_req`=0.
  - On that transition: latch `dir_req` into `Direction`, and set `sw` = min(`RAMP_START`, `speed_req`).
- **RUN**
  - Outputs: `coast`=0, `brake`=0.
  - A 17+ bit ramp counter counts up to `RAMP_DIV`.
  - When it wraps and `sw` < `speed_req`, `sw` increments by 1 and the counter reloads at 0.
  - If `speed_req` < `sw`, `sw` takes the value of `speed_req` on the next cycle. Decreases are immediate.
  - `sw` never exceeds `speed_req` and never wraps past 63.
  - `go`=0 returns to IDLE.
  - `dir_req` ≠ `Direction` or `brake_req`=1 goes to BRAKE.
- **BRAKE**
  - Outputs: `brake`=1, `coast`=0, `sw`=0, `busy`=1. `Direction` holds its old value.
  - The brake counter runs 0..`BRAKE_CYC`-1. While `brake_req`=1 the counter holds at its terminal value.
  - On expiry with `brake_req`=0:
    - `go`=1: go to RUN, latching the current `dir_req` with the `RAMP_START` speed.
    - `go`=0: go to IDLE.
  - A `dir_req` change during BRAKE does not restart the counter. The value present at exit is the one used.
- **FAULT**
  - Outputs: `brake`=1, `coast`=0, `sw`=0, `fault`=1, `busy`=0.
  - Leaves to IDLE only on `fault_clr`=1 with `go`=0. `fault_clr` with `go`=1 is ignored.
- **Stall counter**
  - Counts only in RUN while `st_in`=1.
  - Clears when `st_in`=0 or on leaving RUN.
  - Reaching `STALL_CYC` goes to FAULT, overriding any simultaneous direction change or `brake_req`.
- `rst_n` low in any state returns all outputs to their reset values immediately, regardless of the clock. This includes mid-BRAKE and FAULT.

## Timing
- Input-to-output latency is 1 clock. Outputs update on the edge after the sampling edge.
- Direction change in RUN:
  - `brake` goes high 1 cycle after `dir_req` changes.
  - `brake` stays high exactly `BRAKE_CYC` cycles (when `brake_req`=0).
  - The new `Direction` appears in the same cycle `brake` falls.
- The first ramp step occurs `RAMP_DIV` cycles after the first RUN output cycle.
- Stall: `fault` asserts 1 cycle after the `STALL_CYC`-th consecutive `st_in`-high RUN cycle.
- `Direction`, `brake` and `coast` are never simultaneously active inconsistently: `brake` and `coast` are mutually exclusive in every cycle after reset.

## Test plan
Parameters for all tests: `BRAKE_CYC`=4, `RAMP_DIV`=3, `STALL_CYC`=5, `RAMP_START`=8.

1. Reset, then `go`=1, `dir_req`=001, `speed_req`=10.
   - Next cycle: `Direction`=001, `sw`=8, `coast`=0.
   - `sw`=9 after 3 cycles, `sw`=10 after 6 cycles, then holds at 10.
2. In RUN with `sw`=10, change `dir_req` to 010.
   - `brake`=1 and `sw`=0 for exactly 4 cycles.
   - Then `Direction`=010, `sw`=8, `brake`=0.
3. Hold `brake_req`=1 for 10 cycles during RUN.
   - `brake` is high for all 10 cycles plus the remaining count.
   - On release with `go`=1, returns to RUN at `sw`=8.
4. `st_in`=1 for 4 cycles, low for 1, then high for 5, all in RUN.
   - No fault after the first burst.
   - `fault`=1, `brake`=1, `sw`=0 after the fifth consecutive cycle of the second burst.
5. In FAULT:
   - Pulse `fault_clr` with `go`=1: no change.
   - Set `go`=0, then pulse `fault_clr`: `fault`=0, `coast`=1 next cycle.
6. Drop `rst_n` mid-BRAKE, asynchronously between edges.
   - Outputs immediately become `Direction`=000, `coast`=1, `brake`=0, `sw`=0, `busy`=0.
